writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//   SEQ writeback stage + architectural register file, directly downstream of memory stage.
//   Commits valE/valM to dstE/dstM at the rising clock edge.
//   Supplies combinational valA/valB to decode.
//   Owns the processor status register, the RUN/HALTED state machine and the retired-instruction counter.
// PARAMETERS
//   DATA_W   64         register/data width
//   NREGS    15         architectural registers; IDs 0..14, ID 15 = RNONE
//   SP_INIT  64'h0      reset value of %rsp (reg 4); all other regs reset to 0
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   icode        in   4       instruction code of the instruction in writeback
//   cnd          in   1       condition flag from execute (gates cmovXX)
//   dstE         in   4       destination ID for valE (15 = none)
//   dstM         in   4       destination ID for valM (15 = none)
//   valE         in   DATA_W  ALU result
//   valM         in   DATA_W  memory read data
//   dmem_error   in   1       data-memory address error from memory stage
//   imem_error   in   1       instruction-fetch address error
//   instr_valid  in   1       0 = illegal icode/ifun
//   srcA         in   4       read port A register ID
//   srcB         in   4       read port B register ID
//   valA         out  DATA_W  register[srcA]; 0 when srcA = 15
//   valB         out  DATA_W  register[srcB]; 0 when srcB = 15
//   stat         out  3       1=AOK, 2=HLT, 3=ADR, 4=INS
//   halted       out  1       1 while state = HALTED
//   retired      out  64      count of committed instructions
// BEHAVIOUR
//   Reset (async, any cycle):
//     - regs = 0 except reg4 = SP_INIT; stat = AOK; state = RUN; retired = 0; halted = 0.
//     - An in-flight write is discarded.
//   Next-status, priority high to low:
//     - ADR if dmem_error|imem_error
//     - INS if !instr_valid
//     - HLT if icode = 4'h0
//     - else AOK
//   Commit condition:
//     - state = RUN and next-status is AOK.
//     - ADR/INS/HLT cycles perform no register write.
//   E-port write enable:
//     - commit & dstE != 15 & !(icode = 4'h2 & !cnd); a failed cmov writes nothing.
//   M-port write enable:
//     - commit & dstM != 15.
//   Same-register collision (dstE = dstM): M port wins (popq %rsp gets valM).
//   Register file has no writes when state = HALTED.
//   FSM states:
//     - RUN -> HALTED at the edge where next-status != AOK; stat latches that code.
//     - HALTED -> HALTED until rst; stat, regs and retired are frozen and all inputs are ignored.
//   retired:
//     - +1 on each RUN edge with next-status AOK or HLT; halt counts, faults do not.
//     - Wraps modulo 2^64.
//   stat/halted are registered: new values are visible the cycle after the offending instruction.
//   Read ports: combinational from register array, with 0-cycle latency to the written value only after the edge.
// CONFIGURATION
//   WB_BYPASS_EN
//     - defined: valA/valB return the same-cycle write data when srcX matches an enabled write port.
//     - M port takes precedence over E on a double match.
//     - Bypass is suppressed when the write is not enabled (halted, faulting, failed cmov, RNONE).
//   not defined: read ports reflect array contents only; a same-cycle write is visible next cycle.
// TESTING
//   - Reset with SP_INIT=64'h200:
//       -> valA(srcA=4)=0x200, valB(srcB=0)=0, stat=1, retired=0.
//   - irmovq dstE=3 valE=0x55, then srcA=3:
//       -> valA=0x55 next cycle, retired=1.
//   - popq dstE=4 valE=0x208, dstM=4 valM=0x99:
//       -> reg4=0x99.
//   - cmov icode=2 cnd=0 dstE=1 valE=7:
//       -> reg1 unchanged, retired still increments.
//   - mrmovq with dmem_error=1, dstM=2:
//       -> reg2 unchanged, stat=3, halted=1, retired unchanged.
//       -> Further valid writes are ignored until rst.
//   - WB_BYPASS_EN: dstE=5 valE=0xAB with srcB=5 in same cycle:
//       -> valB=0xAB combinationally; without the macro valB=old value.

Source files
------------

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//   Writeback stage and architectural register file of a sequential Y86-64
//   style core, sitting directly after the memory stage. Commits valE/valM
//   to dstE/dstM at the rising clock edge, supplies combinational valA/valB
//   to decode, and owns the processor status register, the RUN/HALTED state
//   machine and the retired-instruction counter.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : valA/valB forward same-cycle enabled write data (M over E).
//   undefined : read ports reflect array contents only.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   icode        in   instruction code in writeback
//   cnd          in   condition flag from execute (gates cmovXX)
//   dstE, dstM   in   destination register IDs (15 = none)
//   valE, valM   in   ALU result / memory read data
//   dmem_error   in   data-memory address error
//   imem_error   in   instruction-fetch address error
//   instr_valid  in   0 = illegal icode/ifun
//   srcA, srcB   in   read port register IDs (15 = none, reads as 0)
//   valA, valB   out  read port data
//   stat         out  1=AOK 2=HLT 3=ADR 4=INS (registered)
//   halted       out  1 while in HALTED
//   retired      out  committed instruction count (wraps mod 2^64)
// ---------------------------------------------------------------------------
module writeback_regfile #(
    parameter int unsigned         DATA_W  = 64,
    parameter int unsigned         NREGS   = 15,
    parameter logic [DATA_W-1:0]   SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              dmem_error,
    input  logic              imem_error,
    input  logic              instr_valid,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [63:0]       retired
);

    localparam logic [3:0] RNONE       = 4'hF;
    localparam logic [3:0] ICODE_HALT  = 4'h0;
    localparam logic [3:0] ICODE_CMOV  = 4'h2;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_regs [NREGS];
    state_t            r_state;
    state_t            w_state_next;
    stat_t             r_stat;
    stat_t             w_next_stat;
    logic [63:0]       r_retired;
    logic              w_run;
    logic              w_commit;
    logic              w_we_e;
    logic              w_we_m;

    // Status of the instruction currently in writeback, faults first.
    always_comb begin
        w_next_stat = STAT_AOK;
        if (dmem_error || imem_error)
            w_next_stat = STAT_ADR;
        else if (!instr_valid)
            w_next_stat = STAT_INS;
        else if (icode == ICODE_HALT)
            w_next_stat = STAT_HLT;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_RUN && w_next_stat != STAT_AOK)
            w_state_next = S_HALTED;
    end

    // FSM: outputs and write enables
    always_comb begin
        w_run    = (r_state == S_RUN);
        halted   = (r_state == S_HALTED);
        w_commit = w_run && (w_next_stat == STAT_AOK);
        // A cmov whose condition failed writes nothing.
        w_we_e   = w_commit && (dstE != RNONE) && !(icode == ICODE_CMOV && !cnd);
        w_we_m   = w_commit && (dstM != RNONE);
    end

    // Status register latches the offending code on the RUN->HALTED edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stat <= STAT_AOK;
        else if (r_state == S_RUN)
            r_stat <= w_next_stat;
    end

    // Halt retires; faults do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retired <= '0;
        else if (w_run && (w_next_stat == STAT_AOK || w_next_stat == STAT_HLT))
            r_retired <= r_retired + 64'd1;
    end

    // Register file. M is written after E so it wins on dstE == dstM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= (i == 4) ? SP_INIT : '0;
        end else begin
            if (w_we_e)
                r_regs[dstE] <= valE;
            if (w_we_m)
                r_regs[dstM] <= valM;
        end
    end

    // Read port A
    always_comb begin
        valA = '0;
        if (srcA != RNONE)
            valA = r_regs[srcA];
`ifdef WB_BYPASS_EN
        if (w_we_m && dstM == srcA)
            valA = valM;
        else if (w_we_e && dstE == srcA)
            valA = valE;
`endif
    end

    // Read port B
    always_comb begin
        valB = '0;
        if (srcB != RNONE)
            valB = r_regs[srcB];
`ifdef WB_BYPASS_EN
        if (w_we_m && dstM == srcB)
            valB = valM;
        else if (w_we_e && dstE == srcB)
            valB = valE;
`endif
    end

    assign stat    = r_stat;
    assign retired = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
//   Directed self-checking bench for writeback_regfile with SP_INIT = 0x200.
//   Expected values are hand-computed per scenario.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dmem_error;
    logic        imem_error;
    logic        instr_valid;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_regfile #(
        .DATA_W  (64),
        .NREGS   (15),
        .SP_INIT (64'h200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .icode       (icode),
        .cnd         (cnd),
        .dstE        (dstE),
        .dstM        (dstM),
        .valE        (valE),
        .valM        (valM),
        .dmem_error  (dmem_error),
        .imem_error  (imem_error),
        .instr_valid (instr_valid),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .stat        (stat),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic set_idle();
        icode       = 4'h1;
        cnd         = 1'b0;
        dstE        = 4'hF;
        dstM        = 4'hF;
        valE        = '0;
        valM        = '0;
        dmem_error  = 1'b0;
        imem_error  = 1'b0;
        instr_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        srcA = 4'd4;
        srcB = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (valA !== 64'h200) $display("FAIL reset_sp: valA=%h want 200", valA); else n_pass++;
        n_checks++; if (valB !== 64'h0) $display("FAIL reset_r0: valB=%h want 0", valB); else n_pass++;
        n_checks++; if (stat !== 3'd1) $display("FAIL reset_stat: stat=%0d want 1", stat); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: halted=%b want 0", halted); else n_pass++;
        n_checks++; if (retired !== 64'd0) $display("FAIL reset_retired: retired=%0d want 0", retired); else n_pass++;
    endtask

    task automatic test_irmovq();
        icode = 4'h3; dstE = 4'd3; valE = 64'h55;
        srcA = 4'd3;
        tick();
        set_idle();
        n_checks++; if (valA !== 64'h55) $display("FAIL irmovq_val: valA=%h want 55", valA); else n_pass++;
        n_checks++; if (retired !== 64'd1) $display("FAIL irmovq_ret: retired=%0d want 1", retired); else n_pass++;
    endtask

    task automatic test_popq_collision();
        icode = 4'hB; dstE = 4'd4; valE = 64'h208; dstM = 4'd4; valM = 64'h99;
        srcA = 4'd4;
        tick();
        set_idle();
        n_checks++; if (valA !== 64'h99) $display("FAIL popq_m_wins: valA=%h want 99", valA); else n_pass++;
        n_checks++; if (retired !== 64'd2) $display("FAIL popq_ret: retired=%0d want 2", retired); else n_pass++;
    endtask

    task automatic test_cmov();
        icode = 4'h2; cnd = 1'b0; dstE = 4'd1; valE = 64'h7;
        srcA = 4'd1;
        #1;
        n_checks++; if (valA !== 64'h0) $display("FAIL cmov_nobypass: valA=%h want 0", valA); else n_pass++;
        tick();
        n_checks++; if (valA !== 64'h0) $display("FAIL cmov_fail_nowrite: valA=%h want 0", valA); else n_pass++;
        n_checks++; if (retired !== 64'd3) $display("FAIL cmov_fail_ret: retired=%0d want 3", retired); else n_pass++;
        cnd = 1'b1; valE = 64'h9;
        tick();
        set_idle();
        n_checks++; if (valA !== 64'h9) $display("FAIL cmov_taken: valA=%h want 9", valA); else n_pass++;
        n_checks++; if (retired !== 64'd4) $display("FAIL cmov_taken_ret: retired=%0d want 4", retired); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [63:0] exp_b;
        icode = 4'h3; dstE = 4'd5; valE = 64'hAB;
        srcB = 4'd5;
        #1;
`ifdef WB_BYPASS_EN
        exp_b = 64'hAB;
`else
        exp_b = 64'h0;
`endif
        n_checks++; if (valB !== exp_b) $display("FAIL bypass_e: valB=%h want %h", valB, exp_b); else n_pass++;
        tick();
        n_checks++; if (valB !== 64'hAB) $display("FAIL bypass_e_after: valB=%h want ab", valB); else n_pass++;
        icode = 4'hB; dstE = 4'd6; valE = 64'h11; dstM = 4'd6; valM = 64'h22;
        srcA = 4'd6; srcB = 4'd6;
        #1;
`ifdef WB_BYPASS_EN
        exp_b = 64'h22;
`else
        exp_b = 64'h0;
`endif
        n_checks++; if (valA !== exp_b) $display("FAIL bypass_double: valA=%h want %h", valA, exp_b); else n_pass++;
        tick();
        set_idle();
        n_checks++; if (valB !== 64'h22) $display("FAIL double_after: valB=%h want 22", valB); else n_pass++;
        n_checks++; if (retired !== 64'd6) $display("FAIL bypass_ret: retired=%0d want 6", retired); else n_pass++;
        // RNONE reads as zero; RNONE destination writes nothing
        icode = 4'h3; dstE = 4'hF; valE = 64'hDEAD;
        srcA = 4'hF; srcB = 4'hF;
        #1;
        n_checks++; if (valA !== 64'h0) $display("FAIL rnone_a: valA=%h want 0", valA); else n_pass++;
        n_checks++; if (valB !== 64'h0) $display("FAIL rnone_b: valB=%h want 0", valB); else n_pass++;
        tick();
        set_idle();
        srcA = 4'd3; srcB = 4'd5;
        #1;
        n_checks++; if (valA !== 64'h55) $display("FAIL rnone_keep3: valA=%h want 55", valA); else n_pass++;
        n_checks++; if (valB !== 64'hAB) $display("FAIL rnone_keep5: valB=%h want ab", valB); else n_pass++;
        n_checks++; if (retired !== 64'd7) $display("FAIL rnone_ret: retired=%0d want 7", retired); else n_pass++;
    endtask

    task automatic test_adr_fault();
        icode = 4'h5; dstM = 4'd2; valM = 64'h77; dmem_error = 1'b1;
        srcA = 4'd2; srcB = 4'd3;
        #1;
        n_checks++; if (valA !== 64'h0) $display("FAIL adr_nobypass: valA=%h want 0", valA); else n_pass++;
        tick();
        set_idle();
        n_checks++; if (valA !== 64'h0) $display("FAIL adr_nowrite: valA=%h want 0", valA); else n_pass++;
        n_checks++; if (stat !== 3'd3) $display("FAIL adr_stat: stat=%0d want 3", stat); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL adr_halted: halted=%b want 1", halted); else n_pass++;
        n_checks++; if (retired !== 64'd7) $display("FAIL adr_ret: retired=%0d want 7", retired); else n_pass++;
        // valid writes while halted are ignored
        icode = 4'h3; dstE = 4'd2; valE = 64'h33; dstM = 4'd3; valM = 64'h44;
        #1;
        n_checks++; if (valA !== 64'h0) $display("FAIL halted_nobypass: valA=%h want 0", valA); else n_pass++;
        tick();
        tick();
        n_checks++; if (valA !== 64'h0) $display("FAIL halted_nowrite2: valA=%h want 0", valA); else n_pass++;
        n_checks++; if (valB !== 64'h55) $display("FAIL halted_nowrite3: valB=%h want 55", valB); else n_pass++;
        n_checks++; if (stat !== 3'd3) $display("FAIL halted_stat: stat=%0d want 3", stat); else n_pass++;
        n_checks++; if (retired !== 64'd7) $display("FAIL halted_ret: retired=%0d want 7", retired); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        icode = 4'h3; dstE = 4'd3; valE = 64'hEE; dstM = 4'hF;
        srcA = 4'd3; srcB = 4'd4;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (stat !== 3'd1) $display("FAIL arst_stat: stat=%0d want 1", stat); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL arst_halted: halted=%b want 0", halted); else n_pass++;
        n_checks++; if (retired !== 64'd0) $display("FAIL arst_ret: retired=%0d want 0", retired); else n_pass++;
        n_checks++; if (valB !== 64'h200) $display("FAIL arst_sp: valB=%h want 200", valB); else n_pass++;
        tick();
        n_checks++; if (valA !== 64'h0) $display("FAIL arst_discard: valA=%h want 0", valA); else n_pass++;
        set_idle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ins_and_priority();
        do_reset();
        icode = 4'h0; instr_valid = 1'b0; dstE = 4'd7; valE = 64'h1;
        srcA = 4'd7;
        tick();
        set_idle();
        n_checks++; if (stat !== 3'd4) $display("FAIL ins_stat: stat=%0d want 4", stat); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL ins_halted: halted=%b want 1", halted); else n_pass++;
        n_checks++; if (retired !== 64'd0) $display("FAIL ins_ret: retired=%0d want 0", retired); else n_pass++;
        n_checks++; if (valA !== 64'h0) $display("FAIL ins_nowrite: valA=%h want 0", valA); else n_pass++;
        do_reset();
        icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b1;
        tick();
        set_idle();
        n_checks++; if (stat !== 3'd3) $display("FAIL adr_over_ins: stat=%0d want 3", stat); else n_pass++;
        n_checks++; if (retired !== 64'd0) $display("FAIL imem_ret: retired=%0d want 0", retired); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        icode = 4'h0; dstE = 4'd7; valE = 64'h5;
        srcA = 4'd7;
        tick();
        set_idle();
        n_checks++; if (stat !== 3'd2) $display("FAIL hlt_stat: stat=%0d want 2", stat); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL hlt_halted: halted=%b want 1", halted); else n_pass++;
        n_checks++; if (retired !== 64'd1) $display("FAIL hlt_ret: retired=%0d want 1", retired); else n_pass++;
        n_checks++; if (valA !== 64'h0) $display("FAIL hlt_nowrite: valA=%h want 0", valA); else n_pass++;
        tick();
        n_checks++; if (retired !== 64'd1) $display("FAIL hlt_frozen_ret: retired=%0d want 1", retired); else n_pass++;
        n_checks++; if (stat !== 3'd2) $display("FAIL hlt_frozen_stat: stat=%0d want 2", stat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_popq_collision();
        test_cmov();
        test_bypass();
        test_adr_fault();
        test_async_reset();
        test_ins_and_priority();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
